// File: rtl/id_ex_stage.sv
// RV32I decode stage and ID/EX pipeline register with load-use hazard detection.
// Register-file read addresses are driven combinationally; everything consumed by EX is registered.
module id_ex_stage #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         id_valid,
  input  logic [N-1:0] id_pc,
  input  logic [31:0]  id_inst,
  output logic [4:0]   rs1_addr,
  output logic [4:0]   rs2_addr,
  input  logic [N-1:0] rs1_data,
  input  logic [N-1:0] rs2_data,
  input  logic         flush,
  input  logic         hold,
  output logic         stall,
  output logic         ex_valid,
  output logic [N-1:0] ex_pc,
  output logic [N-1:0] ex_rs1_data,
  output logic [N-1:0] ex_rs2_data,
  output logic [N-1:0] ex_imm,
  output logic [4:0]   ex_rs1,
  output logic [4:0]   ex_rs2,
  output logic [4:0]   ex_rd,
  output logic [2:0]   ex_funct3,
  output logic         ex_funct7b5,
  output logic [6:0]   ex_opcode,
  output logic         ex_reg_write,
  output logic         ex_mem_read,
  output logic         ex_mem_write,
  output logic         ex_branch,
  output logic         ex_jump,
  output logic         ex_alu_src_imm,
  output logic         ex_illegal
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpOp     = 7'b0110011;

  typedef struct packed {
    logic         valid;
    logic [N-1:0] pc;
    logic [N-1:0] rs1_data;
    logic [N-1:0] rs2_data;
    logic [N-1:0] imm;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [4:0]   rd;
    logic [2:0]   funct3;
    logic         funct7b5;
    logic [6:0]   opcode;
    logic         reg_write;
    logic         mem_read;
    logic         mem_write;
    logic         branch;
    logic         jump;
    logic         alu_src_imm;
    logic         illegal;
  } ex_t;

  ex_t ex_q, ex_d, dec;
  logic        uses_rs1, uses_rs2, load_use;
  logic [31:0] imm32;
  logic [6:0]  opcode;

  assign opcode   = id_inst[6:0];
  assign rs1_addr = id_inst[19:15];
  assign rs2_addr = id_inst[24:20];

  always_comb begin
    imm32    = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    dec          = '0;
    dec.valid    = 1'b1;
    dec.pc       = id_pc;
    dec.rs1_data = rs1_data;
    dec.rs2_data = rs2_data;
    dec.rs1      = rs1_addr;
    dec.rs2      = rs2_addr;
    dec.rd       = id_inst[11:7];
    dec.funct3   = id_inst[14:12];
    dec.funct7b5 = id_inst[30];
    dec.opcode   = opcode;
    case (opcode)
      OpLui, OpAuipc: begin
        dec.reg_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        imm32           = {id_inst[31:12], 12'b0};
      end
      OpJal: begin
        dec.reg_write   = 1'b1;
        dec.jump        = 1'b1;
        dec.alu_src_imm = 1'b1;
        imm32 = {{12{id_inst[31]}}, id_inst[19:12], id_inst[20], id_inst[30:21], 1'b0};
      end
      OpJalr: begin
        dec.reg_write   = 1'b1;
        dec.jump        = 1'b1;
        dec.alu_src_imm = 1'b1;
        uses_rs1        = 1'b1;
        imm32           = {{20{id_inst[31]}}, id_inst[31:20]};
      end
      OpBranch: begin
        dec.branch = 1'b1;
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
        imm32 = {{20{id_inst[31]}}, id_inst[7], id_inst[30:25], id_inst[11:8], 1'b0};
      end
      OpLoad, OpOpImm: begin
        dec.reg_write   = 1'b1;
        dec.mem_read    = (opcode == OpLoad);
        dec.alu_src_imm = 1'b1;
        uses_rs1        = 1'b1;
        imm32           = {{20{id_inst[31]}}, id_inst[31:20]};
      end
      OpStore: begin
        dec.mem_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        uses_rs1        = 1'b1;
        uses_rs2        = 1'b1;
        imm32           = {{20{id_inst[31]}}, id_inst[31:25], id_inst[11:7]};
      end
      OpOp: begin
        dec.reg_write = 1'b1;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
      end
      default: begin
        dec.illegal = 1'b1;
        uses_rs1    = 1'b1;
      end
    endcase
    if (dec.rd == 5'd0) dec.reg_write = 1'b0;
    dec.imm = N'($signed(imm32));
  end

  assign load_use = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) &
                    ((uses_rs1 & (ex_q.rd == rs1_addr)) | (uses_rs2 & (ex_q.rd == rs2_addr)));
  assign stall    = load_use & ~flush & ~hold;

  // Bubble is the all-zero (reset) encoding of the EX register.
  always_comb begin
    ex_d = ex_q;
    if (flush)         ex_d = '0;
    else if (hold)     ex_d = ex_q;
    else if (load_use) ex_d = '0;
    else if (id_valid) ex_d = dec;
    else               ex_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  assign ex_valid       = ex_q.valid;
  assign ex_pc          = ex_q.pc;
  assign ex_rs1_data    = ex_q.rs1_data;
  assign ex_rs2_data    = ex_q.rs2_data;
  assign ex_imm         = ex_q.imm;
  assign ex_rs1         = ex_q.rs1;
  assign ex_rs2         = ex_q.rs2;
  assign ex_rd          = ex_q.rd;
  assign ex_funct3      = ex_q.funct3;
  assign ex_funct7b5    = ex_q.funct7b5;
  assign ex_opcode      = ex_q.opcode;
  assign ex_reg_write   = ex_q.reg_write;
  assign ex_mem_read    = ex_q.mem_read;
  assign ex_mem_write   = ex_q.mem_write;
  assign ex_branch      = ex_q.branch;
  assign ex_jump        = ex_q.jump;
  assign ex_alu_src_imm = ex_q.alu_src_imm;
  assign ex_illegal     = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: expected EX contents are queued as stimulus is driven
// and compared after the capturing edge.
module tb_id_ex_stage;
  localparam int unsigned N = 32;
  localparam int KBub  = 0;
  localparam int KCap  = 1;
  localparam int KKeep = 2;

  localparam logic [31:0] AddiX5   = 32'hFFF00293;
  localparam logic [31:0] BeqM4    = 32'hFE208EE3;
  localparam logic [31:0] LwX6     = 32'h0000A303;
  localparam logic [31:0] LwX0     = 32'h0000A003;
  localparam logic [31:0] AddX7X6  = 32'h002303B3;
  localparam logic [31:0] AddX7X0  = 32'h002003B3;
  localparam logic [31:0] SwX2     = 32'h0020A223;
  localparam logic [31:0] JalX1    = 32'h008000EF;
  localparam logic [31:0] LuiX3    = 32'h123451B7;
  localparam logic [31:0] JalrX0   = 32'h00008067;
  localparam logic [31:0] Unknown  = 32'h0000007F;

  logic         clk = 1'b0;
  logic         rst, id_valid, flush, hold, stall;
  logic [N-1:0] id_pc, rs1_data, rs2_data;
  logic [31:0]  id_inst;
  logic [4:0]   rs1_addr, rs2_addr;
  logic         ex_valid, ex_funct7b5, ex_reg_write, ex_mem_read, ex_mem_write;
  logic         ex_branch, ex_jump, ex_alu_src_imm, ex_illegal;
  logic [N-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]   ex_rs1, ex_rs2, ex_rd;
  logic [2:0]   ex_funct3;
  logic [6:0]   ex_opcode;

  id_ex_stage #(.N(N)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .hold(hold), .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_funct7b5(ex_funct7b5), .ex_opcode(ex_opcode), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_alu_src_imm(ex_alu_src_imm), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        valid;
    logic [31:0] pc, imm, rs1d, rs2d;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7;
    logic [6:0]  op;
    logic        rw, mr, mw, br, jp, asi, ill;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_exp;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  function automatic exp_t bubble(input string tag);
    exp_t e;
    e.tag = tag; e.valid = 1'b0; e.pc = '0; e.imm = '0; e.rs1d = '0; e.rs2d = '0;
    e.rs1 = '0; e.rs2 = '0; e.rd = '0; e.f3 = '0; e.f7 = 1'b0; e.op = '0;
    e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.br = 1'b0; e.jp = 1'b0; e.asi = 1'b0;
    e.ill = 1'b0;
    return e;
  endfunction

  // Reference decode written straight from the RV32I encoding tables.
  function automatic exp_t decode(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                                  input logic [31:0] r1d, input logic [31:0] r2d);
    exp_t e;
    e = bubble(tag);
    e.valid = 1'b1; e.pc = pc; e.rs1d = r1d; e.rs2d = r2d;
    e.rs1 = inst[19:15]; e.rs2 = inst[24:20]; e.rd = inst[11:7];
    e.f3 = inst[14:12]; e.f7 = inst[30]; e.op = inst[6:0];
    case (inst[6:0])
      7'h37, 7'h17: begin e.rw = 1'b1; e.asi = 1'b1; e.imm = {inst[31:12], 12'h000}; end
      7'h6F: begin
        e.rw = 1'b1; e.jp = 1'b1; e.asi = 1'b1;
        e.imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      7'h67: begin
        e.rw = 1'b1; e.jp = 1'b1; e.asi = 1'b1; e.imm = {{20{inst[31]}}, inst[31:20]};
      end
      7'h63: begin
        e.br = 1'b1; e.imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      7'h03: begin
        e.rw = 1'b1; e.mr = 1'b1; e.asi = 1'b1; e.imm = {{20{inst[31]}}, inst[31:20]};
      end
      7'h23: begin
        e.mw = 1'b1; e.asi = 1'b1; e.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      7'h13: begin e.rw = 1'b1; e.asi = 1'b1; e.imm = {{20{inst[31]}}, inst[31:20]}; end
      7'h33: e.rw = 1'b1;
      default: e.ill = 1'b1;
    endcase
    if (e.rd == 5'd0) e.rw = 1'b0;
    return e;
  endfunction

  task automatic compare_ex(input exp_t e);
    check_eq({e.tag, ".valid"},   32'(ex_valid),       32'(e.valid));
    check_eq({e.tag, ".pc"},      ex_pc,               e.pc);
    check_eq({e.tag, ".imm"},     ex_imm,              e.imm);
    check_eq({e.tag, ".rs1d"},    ex_rs1_data,         e.rs1d);
    check_eq({e.tag, ".rs2d"},    ex_rs2_data,         e.rs2d);
    check_eq({e.tag, ".rs1"},     32'(ex_rs1),         32'(e.rs1));
    check_eq({e.tag, ".rs2"},     32'(ex_rs2),         32'(e.rs2));
    check_eq({e.tag, ".rd"},      32'(ex_rd),          32'(e.rd));
    check_eq({e.tag, ".funct3"},  32'(ex_funct3),      32'(e.f3));
    check_eq({e.tag, ".f7b5"},    32'(ex_funct7b5),    32'(e.f7));
    check_eq({e.tag, ".opcode"},  32'(ex_opcode),      32'(e.op));
    check_eq({e.tag, ".reg_wr"},  32'(ex_reg_write),   32'(e.rw));
    check_eq({e.tag, ".mem_rd"},  32'(ex_mem_read),    32'(e.mr));
    check_eq({e.tag, ".mem_wr"},  32'(ex_mem_write),   32'(e.mw));
    check_eq({e.tag, ".branch"},  32'(ex_branch),      32'(e.br));
    check_eq({e.tag, ".jump"},    32'(ex_jump),        32'(e.jp));
    check_eq({e.tag, ".alu_imm"}, 32'(ex_alu_src_imm), 32'(e.asi));
    check_eq({e.tag, ".illegal"}, 32'(ex_illegal),     32'(e.ill));
  endtask

  // Drive one ID cycle, check the combinational stall, queue the expected EX state and
  // compare it after the capturing edge.
  task automatic cycle(input string tag, input logic v, input logic [31:0] pc,
                       input logic [31:0] inst, input logic [31:0] r1d, input logic [31:0] r2d,
                       input logic fl, input logic hd, input int kind, input logic exp_stall);
    exp_t e;
    @(negedge clk);
    id_valid = v; id_pc = pc; id_inst = inst; rs1_data = r1d; rs2_data = r2d;
    flush = fl; hold = hd;
    #1;
    check_eq({tag, ".stall"},    32'(stall),    32'(exp_stall));
    check_eq({tag, ".rs1_addr"}, 32'(rs1_addr), 32'(inst[19:15]));
    if (kind == KBub)      e = bubble(tag);
    else if (kind == KCap) e = decode(tag, pc, inst, r1d, r2d);
    else begin
      e = last_exp;
      e.tag = tag;
    end
    sb_q.push_back(e);
    last_exp = e;
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    compare_ex(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_pc = '0; id_inst = '0; rs1_data = '0; rs2_data = '0;
    flush = 1'b0; hold = 1'b0;
    last_exp = bubble("init");
    #1;
    compare_ex(bubble("reset"));
    check_eq("reset.stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    cycle("addi", 1'b1, 32'h0, AddiX5, 32'h0, 32'h0, 1'b0, 1'b0, KCap, 1'b0);
    check_eq("addi.imm_lit", ex_imm, 32'hFFFFFFFF);
    cycle("beq", 1'b1, 32'h100, BeqM4, 32'h11, 32'h22, 1'b0, 1'b0, KCap, 1'b0);
    check_eq("beq.imm_lit", ex_imm, 32'hFFFFFFFC);
    cycle("sw", 1'b1, 32'h104, SwX2, 32'h1000, 32'h55, 1'b0, 1'b0, KCap, 1'b0);
    cycle("jal", 1'b1, 32'h108, JalX1, 32'h0, 32'h0, 1'b0, 1'b0, KCap, 1'b0);
    cycle("lui", 1'b1, 32'h10C, LuiX3, 32'h0, 32'h0, 1'b0, 1'b0, KCap, 1'b0);
    cycle("jalr", 1'b1, 32'h110, JalrX0, 32'h200, 32'h0, 1'b0, 1'b0, KCap, 1'b0);

    // Load-use: one stall cycle with a bubble, then the dependent add issues.
    cycle("lw", 1'b1, 32'h200, LwX6, 32'h1000, 32'h0, 1'b0, 1'b0, KCap, 1'b0);
    cycle("lu_stall", 1'b1, 32'h204, AddX7X6, 32'h0, 32'h7, 1'b0, 1'b0, KBub, 1'b1);
    cycle("lu_issue", 1'b1, 32'h204, AddX7X6, 32'h99, 32'h7, 1'b0, 1'b0, KCap, 1'b0);
    check_eq("lu_issue.rs1_lit", 32'(ex_rs1), 32'd6);
    cycle("lw_x0", 1'b1, 32'h208, LwX0, 32'h1000, 32'h0, 1'b0, 1'b0, KCap, 1'b0);
    cycle("no_lu_x0", 1'b1, 32'h20C, AddX7X0, 32'h0, 32'h7, 1'b0, 1'b0, KCap, 1'b0);

    // Flush overrides a pending load-use.
    cycle("lw2", 1'b1, 32'h300, LwX6, 32'h1000, 32'h0, 1'b0, 1'b0, KCap, 1'b0);
    cycle("lu_flush", 1'b1, 32'h304, AddX7X6, 32'h0, 32'h7, 1'b1, 1'b0, KBub, 1'b0);
    cycle("illegal", 1'b1, 32'h308, Unknown, 32'h3, 32'h4, 1'b0, 1'b0, KCap, 1'b0);
    cycle("idle", 1'b0, 32'h30C, AddiX5, 32'h0, 32'h0, 1'b0, 1'b0, KBub, 1'b0);

    // Hold freezes EX (including over a load-use), release captures the current ID.
    cycle("lw3", 1'b1, 32'h400, LwX6, 32'h2000, 32'h0, 1'b0, 1'b0, KCap, 1'b0);
    cycle("hold0", 1'b1, 32'h404, AddX7X6, 32'h1, 32'h2, 1'b0, 1'b1, KKeep, 1'b0);
    cycle("hold1", 1'b1, 32'h408, BeqM4, 32'h3, 32'h4, 1'b0, 1'b1, KKeep, 1'b0);
    cycle("hold2", 1'b1, 32'h40C, SwX2, 32'h5, 32'h6, 1'b0, 1'b1, KKeep, 1'b0);
    check_eq("hold2.pc_lit", ex_pc, 32'h400);
    cycle("hold_rel", 1'b1, 32'h410, AddiX5, 32'h0, 32'h0, 1'b0, 1'b0, KCap, 1'b0);

    // Asynchronous reset while a stall is pending.
    cycle("lw4", 1'b1, 32'h500, LwX6, 32'h3000, 32'h0, 1'b0, 1'b0, KCap, 1'b0);
    @(negedge clk);
    id_valid = 1'b1; id_pc = 32'h504; id_inst = AddX7X6;
    #1;
    check_eq("pre_rst.stall", 32'(stall), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    compare_ex(bubble("rst_mid"));
    check_eq("rst_mid.stall", 32'(stall), 32'd0);
    id_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    last_exp = bubble("post_rst");
    @(posedge clk);
    #1;
    compare_ex(bubble("post_rst"));
    check_eq("post_rst.stall", 32'(stall), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode stage and ID/EX pipeline register of the RV32I pipeline. It takes the IF/ID instruction, decodes control and immediate, and captures the register-file read data into the EX-stage register. It also detects load-use hazards, inserting a bubble and stalling the front end. It sits between the register file, whose read ports it drives combinationally, and the EX stage/forwarding unit that consume its registered outputs.

## Interface
- N, 32, datapath width of register data, PC and immediate
- clk  in  1  clock; EX register updates on posedge
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  IF/ID holds a real instruction
- id_pc  in  N  PC of IF/ID instruction
- id_inst  in  32  IF/ID instruction word
- rs1_addr  out  5  id_inst[19:15], drives register-file read1
- rs2_addr  out  5  id_inst[24:20], drives register-file read2
- rs1_data  in  N  register-file out1
- rs2_data  in  N  register-file out2
- flush  in  1  EX redirect (taken branch/jump); ID instruction is wrong-path
- hold  in  1  back-end freeze (memory wait); EX register keeps contents
- stall  out  1  load-use stall to PC and IF/ID (hold them this cycle)
- ex_valid  out  1  EX register holds a real instruction
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  N  registered fields
- ex_rs1, ex_rs2, ex_rd  out  5  register indices (for forwarding)
- ex_funct3  out  3; ex_funct7b5  out  1  (inst[30]); ex_opcode  out  7
- ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_alu_src_imm, ex_illegal  out  1 each

## Operation
- Decode on id_inst[6:0]: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
- reg_write: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP; forced 0 when rd==0.
- mem_read: LOAD. mem_write: STORE. branch: BRANCH. jump: JAL, JALR. alu_src_imm: all except OP and BRANCH.
- Any other opcode: ex_illegal=1, ex_valid=1, all other controls 0.
- Immediates, sign-extended from inst[31] to N bits: I (LOAD/OP-IMM/JALR), S, B (bit0=0), U (low 12 bits 0), J (bit0=0). OP gives 0.
- uses_rs1: all except LUI, AUIPC, JAL. uses_rs2: BRANCH, STORE, OP.
- load_use = id_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((uses_rs1 & ex_rd==rs1_addr) | (uses_rs2 & ex_rd==rs2_addr)).
- stall = load_use & ~flush & ~hold (combinational).
- Per posedge, priority: flush -> bubble; else hold -> keep all EX fields; else load_use -> bubble; else id_valid -> capture decoded instruction; else bubble.
- Bubble: every ex_* output takes its reset value (ex_valid=0, all controls 0, data 0).
- No WB bypass: the register file writes on negedge, so rs1_data/rs2_data already reflect a same-cycle WB write by posedge.

## Timing
- Reset: all ex_* outputs 0 immediately on rst, held until first posedge after release. stall=0 during reset.
- Latency: 1 cycle ID -> EX.
- Load-use: stall high exactly one cycle per load-use pair. The bubble then clears ex_mem_read, so the dependent instruction issues the next cycle.
- flush and load_use together: bubble, stall=0.
- hold and load_use together: EX unchanged, stall=0. Detection re-evaluates after hold drops.
- rst asserted mid-stall or mid-hold: outputs clear at once, and no stall is carried over.

## Test plan
- rst pulse mid-stream with valid EX contents -> all ex_* and stall read 0 immediately. First posedge after release with id_valid=0 keeps ex_valid=0.
- id_inst=0xFFF00293 (addi x5,x0,-1), rs1_data=0 -> next edge ex_imm=0xFFFFFFFF, ex_rd=5, ex_reg_write=1, ex_alu_src_imm=1, ex_valid=1.
- id_inst=0xFE208EE3 (beq x1,x2,-4), id_pc=0x100 -> ex_imm=0xFFFFFFFC, ex_branch=1, ex_reg_write=0, ex_pc=0x100.
- 0x0000A303 (lw x6,0(x1)) then 0x002303B3 (add x7,x6,x2) -> stall=1 one cycle, bubble (ex_valid=0), then add in EX with ex_rs1=6. Same sequence with lw rd=x0 -> no stall.
- Load-use pending while flush=1 -> stall=0, ex_valid=0 next edge. Unknown opcode 0x0000007F -> ex_illegal=1, controls 0.
- hold=1 for 3 cycles while id_inst changes -> all ex_* stay constant. On release, the current id_inst is captured at the next edge.
